// File: rtl/issue_queue_free_list.sv
// Free list of issue-queue entry indices: circular FIFO with multi-lane allocate
// (from head) and multi-lane release (to tail), with a sticky overflow flag.
module issue_queue_free_list #(
   parameter  int ENTRY_NUM     = 16,
   parameter  int ALLOC_WIDTH   = 4,
   parameter  int RELEASE_WIDTH = 8,
   localparam int IDX_W         = $clog2(ENTRY_NUM),
   localparam int CNT_W         = $clog2(ENTRY_NUM + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [ALLOC_WIDTH-1:0]               alloc_req,
   output logic [ALLOC_WIDTH-1:0][IDX_W-1:0]    alloc_index,
   output logic                                 allocatable,
   input  logic [RELEASE_WIDTH-1:0]             release_valid,
   input  logic [RELEASE_WIDTH-1:0][IDX_W-1:0]  release_index,
   output logic [CNT_W-1:0]                     free_count,
   output logic                                 overflow_err
);

   localparam int SUM_W = CNT_W + 1;

   logic [IDX_W-1:0] r_storage [ENTRY_NUM];
   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic [IDX_W-1:0] w_aptr;
   logic [SUM_W-1:0] w_apop;
   logic [IDX_W-1:0] w_rptr;
   logic [SUM_W-1:0] w_rpop;
   logic [IDX_W-1:0] w_waddr [RELEASE_WIDTH];
   logic             w_alloc_ok;
   logic [SUM_W-1:0] w_pop;
   logic [SUM_W-1:0] w_sum;
   logic             w_ovf;

   // Lane offsets are running popcounts, so sparse lanes pack densely and wrap naturally.
   always_comb begin
      w_aptr = r_head;
      w_apop = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         alloc_index[k] = r_storage[w_aptr];
         if (alloc_req[k]) begin
            w_aptr = w_aptr + 1'b1;
            w_apop = w_apop + 1'b1;
         end
      end
   end

   always_comb begin
      w_rptr = r_tail;
      w_rpop = '0;
      for (int j = 0; j < RELEASE_WIDTH; j++) begin
         w_waddr[j] = w_rptr;
         if (release_valid[j]) begin
            w_rptr = w_rptr + 1'b1;
            w_rpop = w_rpop + 1'b1;
         end
      end
   end

   // All-or-nothing grant: a partial grant would need lane-level backpressure upstream.
   assign w_alloc_ok = (r_count >= CNT_W'(ALLOC_WIDTH));
   assign w_pop      = w_alloc_ok ? w_apop : '0;
   assign w_sum      = {1'b0, r_count} - w_pop + w_rpop;
   assign w_ovf      = (w_sum > SUM_W'(ENTRY_NUM));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= CNT_W'(ENTRY_NUM);
         r_overflow <= 1'b0;
         for (int i = 0; i < ENTRY_NUM; i++)
            r_storage[i] <= IDX_W'(i);
      end else begin
         if (w_alloc_ok)
            r_head <= w_aptr;
         if (w_ovf) begin
            r_overflow <= 1'b1;
            r_count    <= CNT_W'(ENTRY_NUM);
         end else begin
            r_tail  <= w_rptr;
            r_count <= w_sum[CNT_W-1:0];
            for (int j = 0; j < RELEASE_WIDTH; j++)
               if (release_valid[j])
                  r_storage[w_waddr[j]] <= release_index[j];
         end
      end
   end

   assign allocatable  = w_alloc_ok;
   assign free_count   = r_count;
   assign overflow_err = r_overflow;

endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed bench for issue_queue_free_list: a queue-based free-list model is
// compared every cycle, with literal grant/count expectations pinning the model.
module tb_issue_queue_free_list;

   logic                 clk;
   logic                 rst_n;
   logic [3:0]           alloc_req;
   logic [3:0][3:0]      alloc_index;
   logic                 allocatable;
   logic [7:0]           release_valid;
   logic [7:0][3:0]      release_index;
   logic [4:0]           free_count;
   logic                 overflow_err;

   int n_vec = 0;
   int n_err = 0;
   int mq[$];
   bit m_ovf;

   issue_queue_free_list #(.ENTRY_NUM(16), .ALLOC_WIDTH(4), .RELEASE_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_index(alloc_index),
      .allocatable(allocatable), .release_valid(release_valid),
      .release_index(release_index), .free_count(free_count), .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 16; i++) mq.push_back(i);
      m_ovf = 1'b0;
   endtask

   // Free entries in FIFO order; lane k sees the P(k)-th free entry.
   task automatic compare_model();
      int p;
      check("free_count", int'(free_count), mq.size());
      check("allocatable", int'(allocatable), int'(mq.size() >= 4));
      check("overflow_err", int'(overflow_err), int'(m_ovf));
      p = 0;
      for (int k = 0; k < 4; k++) begin
         if (p < mq.size())
            check($sformatf("alloc_index[%0d]", k), int'(alloc_index[k]), mq[p]);
         if (alloc_req[k]) p++;
      end
   endtask

   task automatic model_update(input logic [3:0] areq, input logic [7:0] rv,
                               input logic [7:0][3:0] ri);
      int r;
      if (mq.size() >= 4)
         for (int k = 0; k < 4; k++)
            if (areq[k]) void'(mq.pop_front());
      r = $countones(rv);
      if (mq.size() + r > 16)
         m_ovf = 1'b1;
      else
         for (int j = 0; j < 8; j++)
            if (rv[j]) mq.push_back(int'(ri[j]));
   endtask

   task automatic step(input logic [3:0] areq, input logic [7:0] rv,
                       input logic [7:0][3:0] ri, input bit lit_en,
                       input logic [3:0][3:0] lit);
      alloc_req     = areq;
      release_valid = rv;
      release_index = ri;
      #1;
      compare_model();
      if (lit_en)
         for (int k = 0; k < 4; k++)
            if (areq[k])
               check($sformatf("lit_grant[%0d]", k), int'(alloc_index[k]), int'(lit[k]));
      @(posedge clk);
      model_update(areq, rv, ri);
      @(negedge clk);
      alloc_req     = '0;
      release_valid = '0;
      release_index = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      alloc_req = '0;
      release_valid = '0;
      release_index = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Drain in four full-width allocations
      step(4'b1111, 8'h00, '0, 1, {4'd3, 4'd2, 4'd1, 4'd0});
      check("lit_free_after_1", int'(free_count), 12);
      step(4'b1111, 8'h00, '0, 1, {4'd7, 4'd6, 4'd5, 4'd4});
      check("lit_free_after_2", int'(free_count), 8);
      step(4'b1111, 8'h00, '0, 1, {4'd11, 4'd10, 4'd9, 4'd8});
      check("lit_free_after_3", int'(free_count), 4);
      step(4'b1111, 8'h00, '0, 1, {4'd15, 4'd14, 4'd13, 4'd12});
      check("lit_free_empty", int'(free_count), 0);
      check("lit_allocatable_empty", int'(allocatable), 0);
      step(4'b0101, 8'h00, '0, 0, '0);
      check("lit_ignored_alloc", int'(free_count), 0);

      // Full-width release, then grants in release-lane order
      step(4'b0000, 8'hFF, {4'd4, 4'd12, 4'd1, 4'd7, 4'd15, 4'd0, 4'd3, 4'd9}, 0, '0);
      check("lit_free_after_rel", int'(free_count), 8);
      check("lit_alloc_after_rel", int'(allocatable), 1);
      step(4'b1111, 8'h00, '0, 1, {4'd15, 4'd0, 4'd3, 4'd9});

      // count=4: allocate four and release two in the same cycle
      step(4'b1111, 8'b0000_0011, {24'h0, 4'd5, 4'd2}, 1, {4'd4, 4'd12, 4'd1, 4'd7});
      check("lit_free_same_cycle", int'(free_count), 2);
      check("lit_alloc_same_cycle", int'(allocatable), 0);
      step(4'b1111, 8'h00, '0, 0, '0);
      check("lit_free_ignored", int'(free_count), 2);

      // Sparse allocate and sparse release
      do_reset();
      step(4'b1010, 8'h00, '0, 1, {4'd1, 4'd0, 4'd0, 4'd0});
      check("lit_free_sparse", int'(free_count), 14);
      step(4'b0000, 8'b0010_0100, {8'h0, 4'd0, 4'd0, 4'd0, 4'd1, 8'h0}, 0, '0);
      check("lit_free_sparse_rel", int'(free_count), 16);

      // Wrap: head moves 2 -> 14, tail 2 -> 14, then a grant crosses slot 15 -> 0
      step(4'b1111, 8'h00, '0, 1, {4'd5, 4'd4, 4'd3, 4'd2});
      step(4'b1111, 8'h00, '0, 1, {4'd9, 4'd8, 4'd7, 4'd6});
      step(4'b1111, 8'h00, '0, 1, {4'd13, 4'd12, 4'd11, 4'd10});
      step(4'b0000, 8'hFF, {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}, 0, '0);
      step(4'b0000, 8'h0F, {16'h0, 4'd2, 4'd13, 4'd12, 4'd11}, 0, '0);
      check("lit_free_wrap", int'(free_count), 16);
      step(4'b1111, 8'h00, '0, 1, {4'd0, 4'd1, 4'd15, 4'd14});
      step(4'b1111, 8'h00, '0, 1, {4'd6, 4'd5, 4'd4, 4'd3});

      // Overflow: release into a full list is dropped and flagged
      do_reset();
      step(4'b0000, 8'h01, {28'h0, 4'd5}, 0, '0);
      check("lit_overflow", int'(overflow_err), 1);
      check("lit_free_overflow", int'(free_count), 16);
      step(4'b1111, 8'h00, '0, 1, {4'd3, 4'd2, 4'd1, 4'd0});
      check("lit_overflow_sticky", int'(overflow_err), 1);
      step(4'b0011, 8'h00, '0, 1, {4'd0, 4'd0, 4'd5, 4'd4});

      // Asynchronous reset mid-cycle with requests in flight
      alloc_req     = 4'b1111;
      release_valid = 8'h01;
      release_index = {28'h0, 4'd9};
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_model();
      check("lit_rst_ovf", int'(overflow_err), 0);
      check("lit_rst_free", int'(free_count), 16);
      for (int k = 0; k < 4; k++)
         check($sformatf("lit_rst_lane[%0d]", k), int'(alloc_index[k]), k);
      @(negedge clk);
      alloc_req     = '0;
      release_valid = '0;
      release_index = '0;
      rst_n = 1'b1;
      step(4'b1111, 8'h00, '0, 1, {4'd3, 4'd2, 4'd1, 4'd0});
      check("lit_free_post_rst", int'(free_count), 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
